// File: rtl/char_line_renderer.sv
// Four-glyph text line renderer: drives the character ROM address from pixel coordinates and
// serialises the returned row bytes into a 1-bit pixel stream with syncs re-aligned to it.
module char_line_renderer #(
  parameter int unsigned X0        = 64,
  parameter int unsigned Y0        = 32,
  parameter bit          SYNC_IDLE = 1'b1
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic [9:0] inHCount,
  input  logic [9:0] inVCount,
  input  logic       inActive,
  input  logic       inHSync,
  input  logic       inVSync,
  input  logic       wrEn,
  input  logic [1:0] wrIdx,
  input  logic [1:0] wrCode,
  output logic [5:0] romAddress,
  input  logic [7:0] romData,
  output logic       outPixel,
  output logic       outHSync,
  output logic       outVSync,
  output logic       outActive
);

  localparam logic [9:0] XLo = 10'(X0);
  localparam logic [9:0] XHi = 10'(X0 + 32);
  localparam logic [9:0] YLo = 10'(Y0);
  localparam logic [9:0] YHi = 10'(Y0 + 16);

  logic       w_in_win;
  logic       w_commit;
  logic [4:0] w_col;
  logic [3:0] w_row;
  logic [1:0] w_slot;
  logic [2:0] w_bit;

  logic [1:0] r_shadow [4];
  logic [1:0] r_live   [4];

  logic [5:0] r_rom_addr;
  logic [2:0] r_bit1, r_bit2;
  logic       r_win1, r_win2;
  logic       r_hs1, r_hs2, r_hs3;
  logic       r_vs1, r_vs2, r_vs3;
  logic       r_act1, r_act2, r_act3;
  logic       r_pixel;

  // Range checks come first, so the truncated offsets below only matter inside the window.
  always_comb begin
    w_in_win = inActive && (inHCount >= XLo) && (inHCount < XHi) &&
               (inVCount >= YLo) && (inVCount < YHi);
    w_commit = (inHCount == 10'd0) && (inVCount == 10'd0);
    w_col    = 5'(inHCount - XLo);
    w_row    = 4'(inVCount - YLo);
    w_slot   = w_col[4:3];
    w_bit    = w_col[2:0];
  end

  // Host writes land in shadow; live only changes at the frame origin, so a frame never tears.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= 2'(i);
        r_live[i]   <= 2'(i);
      end
    end else begin
      if (w_commit) r_live <= r_shadow;
      if (wrEn) r_shadow[wrIdx] <= wrCode;
    end
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      r_rom_addr <= 6'd0;
      r_bit1     <= 3'd0;
      r_bit2     <= 3'd0;
      r_win1     <= 1'b0;
      r_win2     <= 1'b0;
      r_hs1      <= SYNC_IDLE;
      r_hs2      <= SYNC_IDLE;
      r_hs3      <= SYNC_IDLE;
      r_vs1      <= SYNC_IDLE;
      r_vs2      <= SYNC_IDLE;
      r_vs3      <= SYNC_IDLE;
      r_act1     <= 1'b0;
      r_act2     <= 1'b0;
      r_act3     <= 1'b0;
      r_pixel    <= 1'b0;
    end else begin
      if (w_in_win) r_rom_addr <= {r_live[w_slot], w_row};
      r_bit1  <= w_bit;
      r_win1  <= w_in_win;
      r_hs1   <= inHSync;
      r_vs1   <= inVSync;
      r_act1  <= inActive;
      // The ROM registers its byte on this edge; carry the side-band alongside it.
      r_bit2  <= r_bit1;
      r_win2  <= r_win1;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      r_act2  <= r_act1;
      r_pixel <= r_win2 & romData[3'd7 - r_bit2];
      r_hs3   <= r_hs2;
      r_vs3   <= r_vs2;
      r_act3  <= r_act2;
    end
  end

  assign romAddress = r_rom_addr;
  assign outPixel   = r_pixel;
  assign outHSync   = r_hs3;
  assign outVSync   = r_vs3;
  assign outActive  = r_act3;

endmodule

// File: tb/tb_char_line_renderer.sv
// Scoreboard bench for char_line_renderer with a registered ROM model and a reference
// model of the window, double buffer and three-cycle pipeline.
module tb_char_line_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] h, v;
  logic       act, hs, vs, we;
  logic [1:0] widx, wcode;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       pix, ohs, ovs, oact;

  always #5 clk = ~clk;

  char_line_renderer #(.X0(64), .Y0(32), .SYNC_IDLE(1'b1)) dut (
    .pixelClk  (clk),
    .reset     (reset),
    .inHCount  (h),
    .inVCount  (v),
    .inActive  (act),
    .inHSync   (hs),
    .inVSync   (vs),
    .wrEn      (we),
    .wrIdx     (widx),
    .wrCode    (wcode),
    .romAddress(rom_addr),
    .romData   (rom_data),
    .outPixel  (pix),
    .outHSync  (ohs),
    .outVSync  (ovs),
    .outActive (oact)
  );

  function automatic logic [7:0] rom_fn(input logic [5:0] a);
    case (a)
      6'h00:   rom_fn = 8'h0C;
      6'h30:   rom_fn = 8'hC6;
      6'h3F:   rom_fn = 8'h7E;
      default: rom_fn = {a[2:0], a[5:1]} ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  typedef struct packed {
    logic pix;
    logic hs;
    logic vs;
    logic act;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  bit         e_valid;
  logic [5:0] e_addr;
  logic [5:0] m_addr;
  logic [1:0] m_shadow [4];
  logic [1:0] m_live   [4];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Drive one input cycle, update the model, then sample #1 after the edge.
  task automatic tick(input logic [9:0] hh, input logic [9:0] vv, input logic aa);
    exp_t       x;
    logic       win;
    logic [4:0] col;
    logic [3:0] row;
    logic [1:0] code;
    logic [7:0] b;
    h   = hh;
    v   = vv;
    act = aa;
    win = aa && hh >= 10'd64 && hh < 10'd96 && vv >= 10'd32 && vv < 10'd48;
    col = 5'(hh - 10'd64);
    row = 4'(vv - 10'd32);
    if (reset) begin
      q.delete();
      x = '{pix: 1'b0, hs: 1'b1, vs: 1'b1, act: 1'b0};
      repeat (3) q.push_back(x);
      m_addr = 6'd0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 2'(i);
        m_live[i]   = 2'(i);
      end
    end else begin
      code = m_live[col[4:3]];
      b    = rom_fn({code, row});
      if (win) m_addr = {code, row};
      x.pix = win ? b[3'd7 - col[2:0]] : 1'b0;
      x.hs  = hs;
      x.vs  = vs;
      x.act = aa;
      q.push_back(x);
      if (hh == 10'd0 && vv == 10'd0) m_live = m_shadow;
      if (we) m_shadow[widx] = wcode;
    end
    @(posedge clk);
    #1;
    e_addr  = m_addr;
    e_valid = q.size() >= 3;
    if (e_valid) e = q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1; hs = 1'b1; vs = 1'b1; we = 1'b0; widx = 2'd0; wcode = 2'd0;
    tick(10'd700, 10'd500, 1'b0);
    reset = 1'b0;
    n_cmp++; if (pix !== 1'b0) begin n_bad++; $display("FAIL reset_pix got %b want 0", pix); end
    n_cmp++; if (ohs !== 1'b1) begin n_bad++; $display("FAIL reset_hs got %b want 1", ohs); end
    n_cmp++; if (ovs !== 1'b1) begin n_bad++; $display("FAIL reset_vs got %b want 1", ovs); end
    n_cmp++; if (oact !== 1'b0) begin n_bad++; $display("FAIL reset_act got %b want 0", oact); end
    n_cmp++;
    if (rom_addr !== 6'h00) begin n_bad++; $display("FAIL reset_addr got %h want 00", rom_addr); end
  endtask

  // Window entry, boundaries and inactive coordinates, followed by a flush.
  task automatic test_window();
    logic [9:0] th [12] = '{10'd64, 10'd68, 10'd95, 10'd96, 10'd64, 10'd63, 10'd68, 10'd80,
                            10'd700, 10'd700, 10'd700, 10'd700};
    logic [9:0] tv [12] = '{10'd32, 10'd32, 10'd47, 10'd47, 10'd48, 10'd40, 10'd32, 10'd31,
                            10'd500, 10'd500, 10'd500, 10'd500};
    logic       ta [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      tick(th[i], tv[i], ta[i]);
      n_cmp++;
      if (rom_addr !== e_addr) begin
        n_bad++; $display("FAIL window_addr[%0d] got %h want %h", i, rom_addr, e_addr);
      end
      n_cmp++;
      if (!e_valid || pix !== e.pix) begin
        n_bad++; $display("FAIL window_pix[%0d] got %b want %b", i, pix, e.pix);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 44; i++) begin
      if (i < 41) tick(10'(60 + i), 10'd40, 1'b1);
      else tick(10'd700, 10'd500, 1'b0);
      n_cmp++;
      if (!e_valid || pix !== e.pix || rom_addr !== e_addr) begin
        n_bad++;
        $display("FAIL b2b[%0d] pix got %b want %b addr got %h want %h",
                 i, pix, e.pix, rom_addr, e_addr);
      end
    end
  endtask

  task automatic test_commit();
    we = 1'b1; widx = 2'd0; wcode = 2'd3;
    tick(10'd10, 10'd100, 1'b1);
    we = 1'b0;
    tick(10'd64, 10'd32, 1'b1);
    n_cmp++;
    if (rom_addr !== 6'h00 || rom_addr !== e_addr) begin
      n_bad++; $display("FAIL commit_pre_addr got %h want 00", rom_addr);
    end
    tick(10'd0, 10'd0, 1'b0);
    tick(10'd64, 10'd32, 1'b1);
    n_cmp++;
    if (rom_addr !== 6'h30 || rom_addr !== e_addr) begin
      n_bad++; $display("FAIL commit_post_addr got %h want 30", rom_addr);
    end
    repeat (3) begin
      tick(10'd700, 10'd500, 1'b0);
      n_cmp++;
      if (!e_valid || pix !== e.pix) begin
        n_bad++; $display("FAIL commit_pix got %b want %b", pix, e.pix);
      end
    end
  endtask

  task automatic test_write_on_commit();
    we = 1'b1; widx = 2'd1; wcode = 2'd0;
    tick(10'd0, 10'd0, 1'b0);
    we = 1'b0;
    tick(10'd72, 10'd32, 1'b1);
    n_cmp++;
    if (rom_addr !== 6'h10 || rom_addr !== e_addr) begin
      n_bad++; $display("FAIL woc_same_frame_addr got %h want 10", rom_addr);
    end
    tick(10'd0, 10'd0, 1'b0);
    tick(10'd72, 10'd32, 1'b1);
    n_cmp++;
    if (rom_addr !== 6'h00 || rom_addr !== e_addr) begin
      n_bad++; $display("FAIL woc_next_frame_addr got %h want 00", rom_addr);
    end
  endtask

  task automatic test_sync();
    for (int i = 0; i < 120; i++) begin
      hs = !(i >= 10 && i <= 105);
      vs = !(i >= 20 && i <= 60);
      tick(10'd700, 10'd500, (i >= 30 && i <= 90));
      n_cmp++;
      if (!e_valid || ohs !== e.hs || ovs !== e.vs || oact !== e.act) begin
        n_bad++;
        $display("FAIL sync[%0d] got hs%b vs%b act%b want hs%b vs%b act%b",
                 i, ohs, ovs, oact, e.hs, e.vs, e.act);
      end
      // Sample after input cycle i shows input i-2 (cycle i+1 = (i-2)+3).
      n_cmp++;
      if (ohs !== !(i - 2 >= 10 && i - 2 <= 105)) begin
        n_bad++; $display("FAIL hsync_latency[%0d] got %b", i, ohs);
      end
    end
    hs = 1'b1; vs = 1'b1;
  endtask

  task automatic test_reset_mid();
    tick(10'd68, 10'd32, 1'b1);
    tick(10'd69, 10'd33, 1'b1);
    reset = 1'b1; hs = 1'b0; vs = 1'b0;
    tick(10'd70, 10'd34, 1'b1);
    reset = 1'b0; hs = 1'b1; vs = 1'b1;
    n_cmp++;
    if (pix !== 1'b0 || ohs !== 1'b1 || ovs !== 1'b1 || oact !== 1'b0 || rom_addr !== 6'h00) begin
      n_bad++;
      $display("FAIL midreset_state got pix%b hs%b vs%b act%b addr%h want 0 1 1 0 00",
               pix, ohs, ovs, oact, rom_addr);
    end
    repeat (3) begin
      tick(10'd700, 10'd500, 1'b0);
      n_cmp++;
      if (pix !== 1'b0 || !e_valid || pix !== e.pix) begin
        n_bad++; $display("FAIL midreset_spurious got %b want 0", pix);
      end
    end
    tick(10'd64, 10'd32, 1'b1);
    n_cmp++;
    if (rom_addr !== 6'h00 || rom_addr !== e_addr) begin
      n_bad++; $display("FAIL midreset_buf0 got %h want 00", rom_addr);
    end
    tick(10'd72, 10'd32, 1'b1);
    n_cmp++;
    if (rom_addr !== 6'h10 || rom_addr !== e_addr) begin
      n_bad++; $display("FAIL midreset_buf1 got %h want 10", rom_addr);
    end
  endtask

  initial begin
    reset = 1'b0; h = 10'd700; v = 10'd500; act = 1'b0;
    hs = 1'b1; vs = 1'b1; we = 1'b0; widx = 2'd0; wcode = 2'd0;
    @(negedge clk);
    test_reset();
    test_window();
    test_back_to_back();
    test_commit();
    test_write_on_commit();
    test_sync();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/char_line_renderer.md
# char_line_renderer

Pixel-stream glyph renderer that sits directly upstream and downstream of the 64-entry character ROM in the VGA path. It takes the timing generator's pixel coordinates, drives the ROM address for a four-glyph text line at a fixed screen position, and serialises the returned 8-bit row bytes into a 1-bit pixel stream. Sync signals are re-aligned to that stream. A double-buffered four-entry digit register holds the line contents, so host writes never tear a frame.

## Interface
Parameters:
- X0, 64: left pixel column of the text window.
- Y0, 32: top line of the text window.
- SYNC_IDLE, 1: reset and idle level of outHSync/outVSync.

Ports:
- pixelClk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- inHCount  in  10  current pixel column from the timing generator.
- inVCount  in  10  current line from the timing generator.
- inActive  in  1  visible-area flag.
- inHSync  in  1  horizontal sync from the timing generator.
- inVSync  in  1  vertical sync from the timing generator.
- wrEn  in  1  digit-buffer write strobe.
- wrIdx  in  2  glyph slot to write; 0 is the leftmost slot.
- wrCode  in  2  glyph code to write (0..3, shown as "1".."4").
- romAddress  out  6  address to the character ROM, {code[1:0], row[3:0]}; registered.
- romData  in  8  ROM row byte; valid one cycle after romAddress; MSB is the leftmost pixel.
- outPixel  out  1  rendered pixel; 1 = foreground.
- outHSync  out  1  inHSync delayed to align with outPixel.
- outVSync  out  1  inVSync delayed to align with outPixel.
- outActive  out  1  inActive delayed to align with outPixel.

## Operation
- Window:
  - inWin = inActive && X0 ≤ inHCount < X0+32 && Y0 ≤ inVCount < Y0+16.
  - col = (inHCount−X0)[4:0]; slot = col[4:3]; bit = col[2:0]; row = (inVCount−Y0)[3:0].
  - Arithmetic is 10-bit unsigned. Compare before subtracting, so no wrap is produced outside the window.
- Digit buffer:
  - Two 4×2-bit arrays, shadow and live.
  - wrEn writes wrCode into shadow[wrIdx].
  - Commit event: inHCount==0 && inVCount==0. On it, live <= shadow. The value used is shadow before the edge, so a same-cycle write reaches shadow only and becomes visible at the next commit.
  - Rendering reads live only.
- Pipeline, for an input presented in cycle n:
  - S1 (edge ending n):
    - If inWin: romAddress <= {live[slot], row}; otherwise romAddress holds its value.
    - bit1 <= bit; win1 <= inWin; the three syncs are captured.
  - S2 (edge ending n+1): the ROM registers its data. The block carries bit2, win2 and the syncs forward.
  - S3 (edge ending n+2): outPixel <= win2 & romData[7−bit2]. outHSync, outVSync and outActive take their stage-2 values.
- Reset values, applied at the first edge with reset=1:
  - outPixel=0, outActive=0, outHSync=outVSync=SYNC_IDLE, romAddress=0.
  - All internal window flags = 0.
  - shadow = live = {0,1,2,3}, giving the display "1234".
- Reset mid-frame:
  - Pipeline contents are discarded; no stale pixel is emitted after reset deasserts.
  - Rendering resumes with the first in-window input after release.

## Timing
- Latency: input cycle n to outPixel/outHSync/outVSync/outActive valid in cycle n+3. Latency is fixed and also applies outside the window.
- ROM contract: romData is sampled exactly one cycle after romAddress changes. No handshake; throughput is one pixel per clock.
- Boundaries:
  - Column X0+31 is the last rendered pixel (slot 3, bit 7).
  - Line Y0+15 is the last rendered row (row 15).
  - X0+32 and Y0+16 give outPixel 0.
- With inActive=0, outPixel is 0 three cycles later, regardless of coordinates.
- A write and a commit in the same cycle: the new code is not live until the following frame.

## Test plan
- After reset, drive h=64, v=32, active → romAddress=0x00 at n+1 and outPixel=0 at n+3. Drive h=68, v=32 → outPixel=1 at n+3 (0x0C, bit 3).
- Drive h=95, v=47 (slot 3, row 15, bit 7) → romAddress=0x3F and outPixel=0. Drive h=96 or v=48 → outPixel=0 with romAddress unchanged.
- Write wrIdx=0, wrCode=3 at v=100 → slot 0 still reads 0x00 for the rest of the frame. After commit at (0,0), h=64, v=32 → romAddress=0x30 and outPixel=1 (0xC6, bit 7).
- Write on the exact commit cycle → change not visible until the next commit.
- inHSync pulse low for cycles 10-105 → outHSync low for cycles 13-108. Same check for inVSync and inActive.
- Assert reset for 1 cycle mid-window → next cycle outPixel=0, syncs=SYNC_IDLE, buffers back to "1234", and no spurious pixel appears in the 3 cycles after release.
